// File: rtl/sobel_window_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_window_ctrl
//
// Sequencer for the 3x3 Sobel window datapath. It follows the incoming video
// stream, keeps per-frame column/row counters, writes each accepted pixel into
// one of three rotating line buffers, and tells the Sobel core which window
// centre is currently complete. The final image row has no row below it, so
// after the last write an extra "drain" line of centres is issued without any
// line-buffer writes. The FSM runs WAIT_VS -> WAIT_DE -> ACTIVE -> DRAIN.
//
// Ports
//   I_PCLK        pixel clock, all logic on the rising edge
//   I_RST         asynchronous active-high reset
//   I_VSYNC       vertical sync, active level set by VS_POL
//   I_DE          data enable, one pixel per cycle while high
//   O_LB_WR_EN    line-buffer write strobe (one cycle after pixel accept)
//   O_LB_WR_ADDR  line-buffer write address (column)
//   O_LB_WR_SEL   which of the three line buffers is written (0,1,2)
//   O_WIN_VALID   window centre valid this cycle
//   O_WIN_ROW     window centre row
//   O_WIN_COL     window centre column
//   O_BORDER      centre lies on the image edge (Sobel output forced to 0)
//   O_FRAME_DONE  one-cycle pulse after the last centre of a frame
//   O_SYNC_ERR    one-cycle pulse on a malformed frame
//   O_STATE       FSM state: 0 WAIT_VS, 1 WAIT_DE, 2 ACTIVE, 3 DRAIN
// ---------------------------------------------------------------------------
module sobel_window_ctrl #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int VS_POL   = 0
) (
  input  logic             I_PCLK,
  input  logic             I_RST,
  input  logic             I_VSYNC,
  input  logic             I_DE,
  output logic             O_LB_WR_EN,
  output logic [COL_W-1:0] O_LB_WR_ADDR,
  output logic [1:0]       O_LB_WR_SEL,
  output logic             O_WIN_VALID,
  output logic [ROW_W-1:0] O_WIN_ROW,
  output logic [COL_W-1:0] O_WIN_COL,
  output logic             O_BORDER,
  output logic             O_FRAME_DONE,
  output logic             O_SYNC_ERR,
  output logic [1:0]       O_STATE
);

  localparam logic             VS_LEVEL  = VS_POL[0];
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_PIXELS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_LINES - 1);
  // Drain counter is one bit wider so it can hold H_PIXELS itself, which
  // marks "all drain centres issued" even when H_PIXELS == 2**COL_W.
  localparam logic [COL_W:0]   DRAIN_LEN = (COL_W + 1)'(H_PIXELS);

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_WAIT_DE = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_vs_act_d;   // previous-cycle "VSYNC is active" level
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [1:0]       r_sel;
  logic [COL_W:0]   r_drain_cnt;

  // Registered output copies
  logic             r_lb_wr_en;
  logic [COL_W-1:0] r_lb_wr_addr;
  logic [1:0]       r_lb_wr_sel;
  logic             r_win_valid;
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;
  logic             r_frame_done;
  logic             r_sync_err;

  logic             w_vs_act;
  logic             w_vs_edge;
  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic [1:0]       w_sel_next;

  assign w_vs_act   = (I_VSYNC == VS_LEVEL);
  assign w_vs_edge  = w_vs_act & ~r_vs_act_d;
  // A VSYNC edge always wins over a coincident pixel: the frame restarts and
  // that pixel is dropped.
  assign w_accept   = I_DE & ~w_vs_edge &
                      ((r_state == ST_WAIT_DE) || (r_state == ST_ACTIVE));
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_sel_next = (r_sel == 2'd2) ? 2'd0 : (r_sel + 2'd1);

  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) begin
      r_state      <= ST_WAIT_VS;
      // Treat VSYNC as already active out of reset, so a sync that happens to
      // be active at release is not mistaken for a fresh edge.
      r_vs_act_d   <= 1'b1;
      r_col        <= '0;
      r_row        <= '0;
      r_sel        <= '0;
      r_drain_cnt  <= '0;
      r_lb_wr_en   <= 1'b0;
      r_lb_wr_addr <= '0;
      r_lb_wr_sel  <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_vs_act_d   <= w_vs_act;

      // Strobes and centre outputs are idle unless set below.
      r_lb_wr_en   <= 1'b0;
      r_lb_wr_addr <= '0;
      r_lb_wr_sel  <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;

      case (r_state)
        ST_WAIT_VS: begin
          if (w_vs_edge) begin
            r_state     <= ST_WAIT_DE;
            r_col       <= '0;
            r_row       <= '0;
            r_sel       <= '0;
            r_drain_cnt <= '0;
          end
        end

        ST_WAIT_DE: begin
          // A repeated VSYNC edge simply re-arms the frame.
          if (w_vs_edge) begin
            r_col       <= '0;
            r_row       <= '0;
            r_sel       <= '0;
            r_drain_cnt <= '0;
          end
        end

        ST_ACTIVE: begin
          if (w_vs_edge) begin
            // Unexpected frame start: report it and restart straight away.
            r_sync_err  <= 1'b1;
            r_state     <= ST_WAIT_DE;
            r_col       <= '0;
            r_row       <= '0;
            r_sel       <= '0;
            r_drain_cnt <= '0;
          end else if (!I_DE && (r_col != '0)) begin
            // DE dropped mid-line: short line, abandon the frame.
            r_sync_err  <= 1'b1;
            r_state     <= ST_WAIT_VS;
          end
          // DE low with col == 0 is an ordinary inter-line blanking gap.
        end

        ST_DRAIN: begin
          if (w_vs_edge) begin
            r_sync_err  <= 1'b1;
            r_state     <= ST_WAIT_DE;
            r_col       <= '0;
            r_row       <= '0;
            r_sel       <= '0;
            r_drain_cnt <= '0;
          end else if (r_drain_cnt == DRAIN_LEN) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_WAIT_VS;
          end else begin
            // Bottom row centres: the row below is implicitly outside the
            // image, so no pixel data is needed and I_DE is ignored.
            r_win_valid <= 1'b1;
            r_win_row   <= ROW_LAST;
            r_win_col   <= r_drain_cnt[COL_W-1:0];
            r_drain_cnt <= r_drain_cnt + (COL_W + 1)'(1);
          end
        end

        default: r_state <= ST_WAIT_VS;
      endcase

      // Pixel acceptance, shared by the first pixel (WAIT_DE, counters
      // already cleared) and every later pixel in ACTIVE.
      if (w_accept) begin
        r_lb_wr_en   <= 1'b1;
        r_lb_wr_addr <= r_col;
        r_lb_wr_sel  <= r_sel;

        // Writing row r completes the window whose centre sits on row r-1.
        if (r_row != '0) begin
          r_win_valid <= 1'b1;
          r_win_row   <= r_row - ROW_W'(1);
          r_win_col   <= r_col;
        end

        if (w_col_last) begin
          r_col <= '0;
          r_sel <= w_sel_next;
          if (w_row_last) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end else begin
            r_row   <= r_row + ROW_W'(1);
            r_state <= ST_ACTIVE;
          end
        end else begin
          r_col   <= r_col + COL_W'(1);
          r_state <= ST_ACTIVE;
        end
      end
    end
  end

  assign O_LB_WR_EN   = r_lb_wr_en;
  assign O_LB_WR_ADDR = r_lb_wr_addr;
  assign O_LB_WR_SEL  = r_lb_wr_sel;
  assign O_WIN_VALID  = r_win_valid;
  assign O_WIN_ROW    = r_win_row;
  assign O_WIN_COL    = r_win_col;
  assign O_FRAME_DONE = r_frame_done;
  assign O_SYNC_ERR   = r_sync_err;
  assign O_STATE      = r_state;

  // Border flag is decoded from the registered centre so it lines up with
  // O_WIN_VALID without an extra pipeline stage.
  assign O_BORDER = r_win_valid &
                    ((r_win_row == '0) || (r_win_row == ROW_LAST) ||
                     (r_win_col == '0) || (r_win_col == COL_LAST));

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_ctrl
//
// Directed bench for sobel_window_ctrl on a small 8x4 image. Expected writes
// and window centres are queued when the stimulus is driven and must appear
// exactly in the sample taken after that clock edge.
// ---------------------------------------------------------------------------
module tb_sobel_window_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 3;
  localparam int RW = 2;

  logic          I_PCLK = 1'b0;
  logic          I_RST;
  logic          I_VSYNC;
  logic          I_DE;
  logic          O_LB_WR_EN;
  logic [CW-1:0] O_LB_WR_ADDR;
  logic [1:0]    O_LB_WR_SEL;
  logic          O_WIN_VALID;
  logic [RW-1:0] O_WIN_ROW;
  logic [CW-1:0] O_WIN_COL;
  logic          O_BORDER;
  logic          O_FRAME_DONE;
  logic          O_SYNC_ERR;
  logic [1:0]    O_STATE;

  sobel_window_ctrl #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .COL_W    (CW),
    .ROW_W    (RW),
    .VS_POL   (0)
  ) dut (
    .I_PCLK       (I_PCLK),
    .I_RST        (I_RST),
    .I_VSYNC      (I_VSYNC),
    .I_DE         (I_DE),
    .O_LB_WR_EN   (O_LB_WR_EN),
    .O_LB_WR_ADDR (O_LB_WR_ADDR),
    .O_LB_WR_SEL  (O_LB_WR_SEL),
    .O_WIN_VALID  (O_WIN_VALID),
    .O_WIN_ROW    (O_WIN_ROW),
    .O_WIN_COL    (O_WIN_COL),
    .O_BORDER     (O_BORDER),
    .O_FRAME_DONE (O_FRAME_DONE),
    .O_SYNC_ERR   (O_SYNC_ERR),
    .O_STATE      (O_STATE)
  );

  always #5 I_PCLK = ~I_PCLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_wr, cnt_win, cnt_border, cnt_done, cnt_err;
  int wr_before;

  logic [31:0] wr_q[$];   // {addr, sel}
  logic [31:0] win_q[$];  // {row, col, border}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] win_exp(input int r, input int c);
    int b;
    b = (r == 0 || r == V - 1 || c == 0 || c == H - 1) ? 1 : 0;
    return 32'(r * 16 + c * 2 + b);
  endfunction

  function automatic logic [31:0] wr_exp(input int c, input int s);
    return 32'(c * 4 + s);
  endfunction

  task automatic clear_counts();
    cnt_wr = 0; cnt_win = 0; cnt_border = 0; cnt_done = 0; cnt_err = 0;
  endtask

  // One clock: drive inputs, wait for the edge, sample 1 time unit later and
  // match the write/centre outputs against whatever was queued for this edge.
  task automatic tick(input logic de, input logic vs);
    logic [31:0] e;
    I_DE = de;
    I_VSYNC = vs;
    @(posedge I_PCLK);
    #1;
    check("wr_en", 32'(O_LB_WR_EN), 32'(wr_q.size() != 0));
    if (wr_q.size() != 0) begin
      e = wr_q.pop_front();
      check("wr_addr_sel", 32'({O_LB_WR_ADDR, O_LB_WR_SEL}), e);
      cnt_wr++;
    end
    check("win_valid", 32'(O_WIN_VALID), 32'(win_q.size() != 0));
    if (win_q.size() != 0) begin
      e = win_q.pop_front();
      check("win_row_col_border", 32'({O_WIN_ROW, O_WIN_COL, O_BORDER}), e);
      cnt_win++;
      cnt_border += int'(O_BORDER);
    end else begin
      check("border_idle", 32'(O_BORDER), 32'd0);
    end
    cnt_done += int'(O_FRAME_DONE);
    cnt_err  += int'(O_SYNC_ERR);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
  endtask

  // Active-low VSYNC pulse; the edge is seen on the first low cycle.
  task automatic vsync_edge();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
  endtask

  task automatic send_line(input int r, input int npix);
    for (int c = 0; c < npix; c++) begin
      wr_q.push_back(wr_exp(c, r % 3));
      if (r >= 1) win_q.push_back(win_exp(r - 1, c));
      tick(1'b1, 1'b1);
      if (r == 1 && c == 0) begin
        check("lat_row1_wr", 32'({O_LB_WR_EN, O_LB_WR_ADDR, O_LB_WR_SEL}), 32'b1_000_01);
        check("lat_row1_win", 32'({O_WIN_VALID, O_WIN_ROW, O_WIN_COL, O_BORDER}), 32'b1_00_000_1);
      end
    end
  endtask

  task automatic drain(input int n, input logic de);
    for (int c = 0; c < n; c++) begin
      win_q.push_back(win_exp(V - 1, c));
      tick(de, 1'b1);
    end
  endtask

  task automatic lines_all();
    gap(1);
    for (int r = 0; r < V; r++) begin
      send_line(r, H);
      if (r < V - 1) gap(2);
    end
  endtask

  task automatic frame_tail(input logic drain_de);
    drain(H, drain_de);
    tick(drain_de, 1'b1);
    check("done_after_last_centre", 32'(O_FRAME_DONE), 32'd1);
    check("done_state", 32'(O_STATE), 32'd0);
  endtask

  task automatic full_frame(input logic drain_de);
    vsync_edge();
    lines_all();
    frame_tail(drain_de);
  endtask

  initial begin
    I_RST = 1'b1;
    I_VSYNC = 1'b1;
    I_DE = 1'b0;
    clear_counts();

    // Reset state
    repeat (3) @(posedge I_PCLK);
    #1;
    check("reset_outputs", 32'({O_LB_WR_EN, O_LB_WR_ADDR, O_LB_WR_SEL, O_WIN_VALID, O_WIN_ROW,
                                O_WIN_COL, O_BORDER, O_FRAME_DONE, O_SYNC_ERR, O_STATE}), 32'd0);
    I_RST = 1'b0;
    gap(2);
    check("idle_state", 32'(O_STATE), 32'd0);

    // Nominal frame
    clear_counts();
    full_frame(1'b0);
    gap(3);
    check("nom_writes", 32'(cnt_wr), 32'd32);
    check("nom_centres", 32'(cnt_win), 32'd32);
    check("nom_borders", 32'(cnt_border), 32'd20);
    check("nom_done_count", 32'(cnt_done), 32'd1);
    check("nom_err_count", 32'(cnt_err), 32'd0);
    $display("frame nominal: writes=%0d centres=%0d borders=%0d done=%0d", cnt_wr, cnt_win, cnt_border, cnt_done);

    // Short line on row 2, then a normal frame
    clear_counts();
    vsync_edge();
    gap(1);
    send_line(0, H); gap(2);
    send_line(1, H); gap(2);
    send_line(2, 5);
    tick(1'b0, 1'b1);
    check("short_err_pulse", 32'(O_SYNC_ERR), 32'd1);
    check("short_state", 32'(O_STATE), 32'd0);
    gap(4);
    check("short_err_count", 32'(cnt_err), 32'd1);
    check("short_no_done", 32'(cnt_done), 32'd0);
    $display("frame short line: err=%0d done=%0d", cnt_err, cnt_done);
    clear_counts();
    full_frame(1'b0);
    gap(2);
    check("recover_done", 32'(cnt_done), 32'd1);
    check("recover_writes", 32'(cnt_wr), 32'd32);
    $display("frame after short line: writes=%0d done=%0d", cnt_wr, cnt_done);

    // VSYNC edge inside ACTIVE at row 1 col 3
    clear_counts();
    vsync_edge();
    gap(1);
    send_line(0, H); gap(2);
    send_line(1, 3);
    tick(1'b0, 1'b0);
    check("vs_err_pulse", 32'(O_SYNC_ERR), 32'd1);
    check("vs_state", 32'(O_STATE), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    lines_all();
    frame_tail(1'b0);
    gap(2);
    check("vs_err_count", 32'(cnt_err), 32'd1);
    check("vs_done_count", 32'(cnt_done), 32'd1);
    $display("frame vsync abort: err=%0d done=%0d", cnt_err, cnt_done);

    // DE held high through DRAIN
    clear_counts();
    full_frame(1'b1);
    gap(2);
    check("drain_de_writes", 32'(cnt_wr), 32'd32);
    check("drain_de_centres", 32'(cnt_win), 32'd32);
    check("drain_de_done", 32'(cnt_done), 32'd1);
    $display("frame drain immunity: writes=%0d centres=%0d", cnt_wr, cnt_win);

    // Async reset in the middle of DRAIN
    clear_counts();
    vsync_edge();
    lines_all();
    drain(3, 1'b0);
    #2;
    I_RST = 1'b1;
    #1;
    check("async_reset_outputs", 32'({O_LB_WR_EN, O_LB_WR_ADDR, O_LB_WR_SEL, O_WIN_VALID, O_WIN_ROW,
                                      O_WIN_COL, O_BORDER, O_FRAME_DONE, O_SYNC_ERR, O_STATE}), 32'd0);
    wr_q.delete();
    win_q.delete();
    repeat (2) @(posedge I_PCLK);
    #1;
    I_RST = 1'b0;
    wr_before = cnt_wr;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    check("post_reset_no_writes", 32'(cnt_wr), 32'(wr_before));
    check("post_reset_state", 32'(O_STATE), 32'd0);
    $display("async reset mid-drain: writes_after_release=%0d", cnt_wr - wr_before);
    clear_counts();
    full_frame(1'b0);
    gap(2);
    check("post_reset_frame_done", 32'(cnt_done), 32'd1);
    $display("frame after reset: writes=%0d done=%0d", cnt_wr, cnt_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Sequencer for the 3x3 edge-detection window datapath in edge_detection_top.
- Watches the incoming video stream (I_VSYNC/I_DE) and keeps per-frame pixel and line counters.
- Drives line-buffer write enable, address and rotation select.
- Issues window-centre coordinates, valid and border flags to the Sobel core.
- Generates the extra drain line for the final image row, plus frame-done and sync-error pulses.

Parameters:
H_PIXELS, 640, active pixels per line
V_LINES, 480, active lines per frame
COL_W, 10, column counter width (must satisfy 2^COL_W >= H_PIXELS)
ROW_W, 9, row counter width (must satisfy 2^ROW_W >= V_LINES)
VS_POL, 0, active level of I_VSYNC (0 = active-low)

Ports:
I_PCLK  in  1  pixel clock, all logic on rising edge
I_RST  in  1  reset, asynchronous, active-high
I_VSYNC  in  1  vertical sync, active level = VS_POL
I_DE  in  1  data enable, active-high, one pixel per cycle
O_LB_WR_EN  out  1  line-buffer write strobe
O_LB_WR_ADDR  out  COL_W  line-buffer write address (column)
O_LB_WR_SEL  out  2  which of the 3 line buffers is written (0,1,2)
O_WIN_VALID  out  1  window centre valid this cycle
O_WIN_ROW  out  ROW_W  window centre row
O_WIN_COL  out  COL_W  window centre column
O_BORDER  out  1  centre lies on the image edge; Sobel output is forced to 0
O_FRAME_DONE  out  1  one-cycle pulse after the last centre of a frame
O_SYNC_ERR  out  1  one-cycle pulse on a malformed frame
O_STATE  out  2  FSM state: 0 WAIT_VS, 1 WAIT_DE, 2 ACTIVE, 3 DRAIN

Behaviour:
- Reset
  - While I_RST=1, all outputs are 0 and the FSM is in WAIT_VS.
  - Internal counters col, row and sel are 0.
  - All outputs are registered.
- FSM
  - WAIT_VS: on the cycle I_VSYNC goes from inactive to active (edge detect), go to WAIT_DE. I_DE is ignored in this state.
  - WAIT_DE: the first cycle with I_DE=1 goes to ACTIVE and accepts that pixel as (row 0, col 0). Counters and sel are cleared on entry to WAIT_DE.
  - ACTIVE, each I_DE=1 cycle accepts pixel (row, col):
    - The next cycle drives O_LB_WR_EN=1, O_LB_WR_ADDR=col, O_LB_WR_SEL=sel (latency 1).
    - If row>=1, the same cycle also drives O_WIN_VALID=1, O_WIN_ROW=row-1, O_WIN_COL=col.
    - If row=0, O_WIN_VALID=0.
  - ACTIVE, end of line (col = H_PIXELS-1 accepted):
    - col wraps to 0 and row increments.
    - sel advances 0->1->2->0.
    - If row was V_LINES-1, go to DRAIN instead.
  - DRAIN:
    - Runs H_PIXELS consecutive cycles, starting the cycle after the final write.
    - Each cycle drives O_WIN_VALID=1, O_WIN_ROW=V_LINES-1, O_WIN_COL=0..H_PIXELS-1, O_LB_WR_EN=0.
    - On the cycle after the last drain centre: O_FRAME_DONE=1, state goes to WAIT_VS.
- O_BORDER is combinational from the registered centre, qualified by O_WIN_VALID. It is 1 when O_WIN_ROW is 0 or V_LINES-1, or O_WIN_COL is 0 or H_PIXELS-1; otherwise 0.
- Error handling
  - In ACTIVE, either of the following pulses O_SYNC_ERR for 1 cycle and sends the FSM to WAIT_VS with no FRAME_DONE:
    - I_DE falls while col != 0 (short line);
    - a VSYNC active edge.
  - If the VSYNC edge coincides with the error, the FSM goes directly to WAIT_DE.
  - In DRAIN, I_DE=1 is ignored with no write. A VSYNC edge during DRAIN pulses O_SYNC_ERR and aborts to WAIT_DE.
- Simultaneous events
  - The end-of-line wrap and the row increment take effect in the same cycle.
  - An I_DE gap (I_DE=0) with col=0 between lines is legal, of any length, with no outputs.
- Reset asserted mid-frame clears everything asynchronously. Operation resumes only at the next VSYNC edge after release.

Test Plan:
- Nominal frame (H_PIXELS=8, V_LINES=4, 2-cycle DE gaps)
  - 32 writes with ADDR 0..7 per line and SEL sequence 0,1,2,0.
  - 24 centres during ACTIVE (rows 0..2) plus 8 in DRAIN (row 3).
  - O_BORDER=1 on 20 of the 32 centres.
  - O_FRAME_DONE pulses exactly once, 1 cycle after centre (3,7).
- Latency: first accepted pixel of row 1
  - The next cycle shows O_LB_WR_EN=1, ADDR=0, SEL=1.
  - Same cycle shows O_WIN_VALID=1, ROW=0, COL=0, BORDER=1.
- Short line: DE drops after 5 pixels of row 2 -> O_SYNC_ERR single pulse, O_STATE=0, no FRAME_DONE. The next full frame completes normally.
- VSYNC inside ACTIVE at row 1 col 3 -> O_SYNC_ERR pulse, O_STATE=1, and counters restart so the next DE pixel is written with ADDR=0, SEL=0.
- DRAIN immunity: hold I_DE=1 during DRAIN -> O_LB_WR_EN stays 0 and the drain centres are unaffected (COL 0..7 in order).
- Async reset asserted mid-DRAIN
  - All outputs go to 0 immediately without a clock edge.
  - After release, I_DE pulses before any VSYNC produce no writes.
